// File: rtl/mux128_scan_arb.sv
// Round-robin scanning arbiter in front of a shared 128:1 read mux.
// A rotating pointer drives the mux select. When the pointed-at entry is
// requesting, its mux data is captured and offered on a valid/ready port.
// The handshake cycle returns a one-hot grant and bumps a completion counter.
module mux128_scan_arb #(
  parameter int n       = 4,
  parameter int address = 7,
  parameter int m       = 128
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [m-1:0]       req_i,
  output logic [address-1:0] sel_o,
  input  logic [n-1:0]       mux_data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [n-1:0]       data_o,
  output logic [address-1:0] idx_o,
  output logic [m-1:0]       gnt_o,
  output logic [15:0]        cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [address-1:0] ptr_q;
  logic               hit;
  logic               hs;

  // m == 2**address, so the natural overflow of the adder is the modulo-m wrap.
  function automatic logic [address-1:0] next_idx(input logic [address-1:0] i);
    return i + address'(1);
  endfunction

  // A hit only counts while actively scanning with the enable still high.
  assign hit   = (state_q == SCAN) && en_i && req_i[ptr_q];
  assign hs    = (state_q == HOLD) && ready_i;
  assign sel_o = ptr_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic plus the valid flag and the one-cycle grant pulse.
  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    gnt_o   = '0;
    case (state_q)
      IDLE: if (en_i) state_d = SCAN;
      SCAN: begin
        if (!en_i)    state_d = IDLE;
        else if (hit) state_d = HOLD;
      end
      HOLD: begin
        valid_o = 1'b1;
        if (ready_i) begin
          gnt_o[idx_o] = 1'b1;
          // The enable is only honoured once the held entry has been taken.
          state_d = en_i ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan pointer: steps on a miss, parks on a hit or when disabled, and
  // restarts just past the served entry so that entry goes to the back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (hs) begin
      ptr_q <= next_idx(idx_o);
    end else if ((state_q == SCAN) && en_i && !hit) begin
      ptr_q <= next_idx(ptr_q);
    end
  end

  // Holding register: captured on the hit and frozen until the next hit, so
  // the requester may drop its request or change its entry while waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= '0;
      idx_o  <= '0;
    end else if (hit) begin
      data_o <= mux_data_i;
      idx_o  <= ptr_q;
    end
  end

  // Completed-handshake counter, free-running modulo 2**16.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  cnt_o <= '0;
    else if (hs)  cnt_o <= cnt_o + 16'd1;
  end

endmodule

// File: tb/tb_mux128_scan_arb.sv
// Bench for mux128_scan_arb: a transaction-level reference model runs beside
// the DUT and is compared every cycle, with directed scenarios pinning
// literal values, followed by a randomized soak.
module tb_mux128_scan_arb;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b1;
  logic         en_i = 1'b0;
  logic [127:0] req_i = '0;
  logic [6:0]   sel_o;
  logic [3:0]   mux_data_i;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [3:0]   data_o;
  logic [6:0]   idx_o;
  logic [127:0] gnt_o;
  logic [15:0]  cnt_o;

  logic [3:0]   mem [128];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Combinational 128:1 mux standing in for mux128to1_n.
  assign mux_data_i = mem[sel_o];

  mux128_scan_arb #(.n(4), .address(7), .m(128)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .req_i(req_i),
    .sel_o(sel_o), .mux_data_i(mux_data_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .idx_o(idx_o),
    .gnt_o(gnt_o), .cnt_o(cnt_o)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit holding   = 1'b0;  // an entry is being offered downstream
  bit scanning  = 1'b0;  // pointer is sweeping for requests
  int m_ptr     = 0;
  int m_idx     = 0;
  int m_data    = 0;
  int m_cnt     = 0;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      holding = 0; scanning = 0; m_ptr = 0; m_idx = 0; m_data = 0; m_cnt = 0;
    end else if (holding) begin
      if (ready_i) begin
        m_cnt    = (m_cnt + 1) % 65536;
        m_ptr    = (m_idx + 1) % 128;
        holding  = 0;
        scanning = en_i;
      end
    end else if (scanning) begin
      if (!en_i) scanning = 0;
      else if (req_i[m_ptr]) begin
        m_data = int'(mem[m_ptr]); m_idx = m_ptr; holding = 1; scanning = 0;
      end else m_ptr = (m_ptr + 1) % 128;
    end else if (en_i) begin
      scanning = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [127:0] g;
    g = (holding && ready_i) ? (128'(1) << m_idx) : 128'(0);
    chk("m_sel",   128'(sel_o),   128'(m_ptr));
    chk("m_valid", 128'(valid_o), 128'(holding));
    chk("m_data",  128'(data_o),  128'(m_data));
    chk("m_idx",   128'(idx_o),   128'(m_idx));
    chk("m_cnt",   128'(cnt_o),   128'(m_cnt));
    chk("m_gnt",   gnt_o,         g);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string nm);
    bit found = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (valid_o) found = 1;
    end
    chk(nm, 128'(found), 128'(1));
  endtask

  initial begin
    int exp3 [3];
    int k;
    bit found;
    exp3[0] = 127; exp3[1] = 0; exp3[2] = 3;
    for (int i = 0; i < 128; i++) mem[i] = 4'($urandom);

    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_cnt",   128'(cnt_o),   128'(0));
    chk("rst_sel",   128'(sel_o),   128'(0));
    step();

    // Single request at entry 5.
    mem[5] = 4'hA; req_i = 128'(1) << 5; en_i = 1'b1; ready_i = 1'b1;
    repeat (7) step();
    @(negedge clk);
    chk("single_valid", 128'(valid_o), 128'(1));
    chk("single_data",  128'(data_o),  128'(4'hA));
    chk("single_idx",   128'(idx_o),   128'(5));
    chk("single_gnt",   gnt_o,         128'(1) << 5);
    chk("model_idx",    128'(m_idx),   128'(5));
    step();
    req_i = '0;
    @(negedge clk);
    chk("single_cnt",  128'(cnt_o),   128'(1));
    chk("single_drop", 128'(valid_o), 128'(0));
    chk("single_sel",  128'(sel_o),   128'(6));
    chk("single_gnt0", gnt_o,         128'(0));

    // Round-robin across the wrap point.
    step();
    req_i[127] = 1'b1; req_i[0] = 1'b1; req_i[3] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      found = 0;
      for (int t = 0; t < 300 && !found; t++) begin
        @(negedge clk);
        if (gnt_o != 0) found = 1;
      end
      chk("rr_seen", 128'(found), 128'(1));
      chk("rr_gnt",  gnt_o, 128'(1) << exp3[j]);
      step();
      req_i[exp3[j]] = 1'b0;
    end

    // Backpressure on entry 9 while its mux input keeps changing.
    mem[9] = 4'h6; req_i = 128'(1) << 9; ready_i = 1'b0;
    wait_valid("bp_wait");
    chk("bp_idx", 128'(idx_o), 128'(9));
    for (int i = 0; i < 10; i++) begin
      step();
      mem[9] = 4'($urandom);
      if (i == 0) req_i = '0;
      @(negedge clk);
      chk("bp_data",  128'(data_o),  128'(4'h6));
      chk("bp_valid", 128'(valid_o), 128'(1));
      chk("bp_gnt0",  gnt_o,         128'(0));
    end
    step();
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_gnt", gnt_o, 128'(1) << 9);
    step();
    ready_i = 1'b0;
    @(negedge clk);
    chk("bp_gnt_once", gnt_o,         128'(0));
    chk("bp_done",     128'(valid_o), 128'(0));
    chk("bp_cnt",      128'(cnt_o),   128'(5));
    chk("model_cnt",   128'(m_cnt),   128'(5));

    // Enable dropped while scanning parks the pointer.
    found = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (sel_o == 7'd20) found = 1;
    end
    chk("en_reach20", 128'(found), 128'(1));
    en_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("en_park_sel", 128'(sel_o), 128'(20));
    end
    step();

    // Enable dropped while holding: transaction still completes, then idle.
    req_i = 128'(1) << 25; en_i = 1'b1; ready_i = 1'b0;
    wait_valid("en_hold_wait");
    chk("en_hold_idx", 128'(idx_o), 128'(25));
    step();
    en_i = 1'b0;
    repeat (3) begin
      step();
      @(negedge clk);
      chk("en_hold_valid", 128'(valid_o), 128'(1));
    end
    step();
    ready_i = 1'b1;
    @(negedge clk);
    chk("en_hold_gnt", gnt_o, 128'(1) << 25);
    step();
    ready_i = 1'b0; req_i = '0;
    repeat (3) begin
      @(negedge clk);
      chk("en_idle_sel",   128'(sel_o),   128'(26));
      chk("en_idle_valid", 128'(valid_o), 128'(0));
    end
    chk("en_cnt", 128'(cnt_o), 128'(6));
    step();

    // Reset asserted mid-hold: everything clears at once, no grant.
    req_i = 128'(1) << 30; en_i = 1'b1;
    wait_valid("rst_hold_wait");
    step();
    ready_i = 1'b1; rst_ni = 1'b0;
    @(negedge clk);
    chk("rst2_valid", 128'(valid_o), 128'(0));
    chk("rst2_sel",   128'(sel_o),   128'(0));
    chk("rst2_cnt",   128'(cnt_o),   128'(0));
    chk("rst2_gnt",   gnt_o,         128'(0));
    chk("rst2_idx",   128'(idx_o),   128'(0));
    step();
    step();

    // Back-to-back: every entry requesting, 256 handshakes in order.
    req_i = '1; en_i = 1'b1; ready_i = 1'b1; rst_ni = 1'b1;
    k = 0;
    for (int t = 0; t < 2000 && k < 256; t++) begin
      @(negedge clk);
      if (gnt_o != 0) begin
        chk("b2b_gnt", gnt_o, 128'(1) << (k % 128));
        k++;
      end
    end
    chk("b2b_count", 128'(k), 128'(256));
    step();
    chk("b2b_cnt",       128'(cnt_o), 128'(256));
    chk("model_b2b_cnt", 128'(m_cnt), 128'(256));

    // Randomized soak against the model.
    req_i = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_ni  = ($urandom_range(0, 399) != 0);
      en_i    = ($urandom_range(0, 9) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) req_i = '0;
      req_i[$urandom_range(0, 127)] = 1'($urandom);
      req_i[$urandom_range(0, 127)] = 1'($urandom);
      mem[$urandom_range(0, 127)] = 4'($urandom);
      if (valid_o) mem[idx_o] = 4'($urandom);
    end
    rst_ni = 1'b1;
    step();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
